// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback and late load returns,
// and keeps a scoreboard of registers with loads in flight. Optional stats: WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pl_valid,
    input  logic [ADDR_WIDTH-1:0] pl_rd,
    input  logic [DATA_WIDTH-1:0] pl_data,
    output logic                  pl_ready,
    input  logic                  ld_issue,
    input  logic [ADDR_WIDTH-1:0] ld_issue_rd,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    input  logic [ADDR_WIDTH-1:0] chk_rd,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
`ifdef WB_ARB_STATS_EN
    output logic [31:0]           pl_grant_cnt,
    output logic [31:0]           ld_grant_cnt,
    output logic [15:0]           force_cnt,
`endif
    output logic                  we_out,
    output logic [ADDR_WIDTH-1:0] ad_out,
    output logic [DATA_WIDTH-1:0] wd_out
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        PL_PRIO  = 1'b0,
        LD_FORCE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              force_entry;
    logic              pl_grant;
    logic              ld_grant;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PL_PRIO;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next state, readies and starvation tracking; readies never look at ld_valid
    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        pl_ready    = 1'b0;
        ld_ready    = 1'b0;
        force_entry = 1'b0;
        case (state)
            PL_PRIO: begin
                pl_ready = 1'b1;
                ld_ready = !pl_valid;
                if (ld_valid && pl_valid) begin
                    starve_nxt = starve_cnt + CNT_W'(1);
                    if (starve_cnt == STARVE_LIMIT) begin
                        state_nxt   = LD_FORCE;
                        force_entry = 1'b1;
                    end
                end else begin
                    starve_nxt = '0;
                end
            end
            LD_FORCE: begin
                ld_ready = 1'b1;
                // ld_ready is 1 here, so this cycle ends in a load grant or with no load pending
                state_nxt  = PL_PRIO;
                starve_nxt = '0;
            end
            default: begin
                state_nxt  = PL_PRIO;
                starve_nxt = '0;
            end
        endcase
    end

    assign pl_grant = pl_valid && pl_ready;
    assign ld_grant = ld_valid && ld_ready;

    // Scoreboard update: a new issue beats a same-index return; x0 never busy
    always_comb begin
        busy_nxt = busy;
        if (ld_grant) begin
            busy_nxt[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs1_busy = busy[chk_rs1];
    assign rs2_busy = busy[chk_rs2];
    assign rd_busy  = busy[chk_rd];

    // Write port register; x0 grants complete the handshake but never write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_out <= 1'b0;
            ad_out <= '0;
            wd_out <= '0;
        end else begin
            we_out <= (pl_grant && (pl_rd != '0)) || (ld_grant && (ld_rd != '0));
            if (pl_grant) begin
                ad_out <= pl_rd;
                wd_out <= pl_data;
            end else if (ld_grant) begin
                ad_out <= ld_rd;
                wd_out <= ld_data;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_grant_cnt <= '0;
            ld_grant_cnt <= '0;
            force_cnt    <= '0;
        end else begin
            if (pl_grant && (pl_grant_cnt != '1)) begin
                pl_grant_cnt <= pl_grant_cnt + 32'd1;
            end
            if (ld_grant && (ld_grant_cnt != '1)) begin
                ld_grant_cnt <= ld_grant_cnt + 32'd1;
            end
            if (force_entry && (force_cnt != '1)) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a behavioural model of
// arbitration, write-port timing and the load scoreboard.
module tb_regfile_wb_arbiter;

    localparam int unsigned AW       = 5;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic          clk;
    logic          rst;
    logic          pl_valid;
    logic [AW-1:0] pl_rd;
    logic [DW-1:0] pl_data;
    logic          pl_ready;
    logic          ld_issue;
    logic [AW-1:0] ld_issue_rd;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic [AW-1:0] chk_rd;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rd_busy;
    logic          we_out;
    logic [AW-1:0] ad_out;
    logic [DW-1:0] wd_out;
`ifdef WB_ARB_STATS_EN
    logic [31:0]   pl_grant_cnt;
    logic [31:0]   ld_grant_cnt;
    logic [15:0]   force_cnt;
`endif

    regfile_wb_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pl_valid    (pl_valid),
        .pl_rd       (pl_rd),
        .pl_data     (pl_data),
        .pl_ready    (pl_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
`ifdef WB_ARB_STATS_EN
        .pl_grant_cnt(pl_grant_cnt),
        .ld_grant_cnt(ld_grant_cnt),
        .force_cnt   (force_cnt),
`endif
        .we_out      (we_out),
        .ad_out      (ad_out),
        .wd_out      (wd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed;
    int total;

    // Reference model state
    logic [31:0] m_busy;
    int          lose_run;     // consecutive cycles the pending load has lost
    logic        exp_we;
    logic [AW-1:0] exp_ad;
    logic [DW-1:0] exp_wd;
    int          m_pl_grants;
    int          m_ld_grants;
    int          m_forces;
    logic        plg;
    logic        ldg;
    logic        obs_plr;
    logic        obs_ldr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy      = '0;
        lose_run    = 0;
        exp_we      = 1'b0;
        exp_ad      = '0;
        exp_wd      = '0;
        m_pl_grants = 0;
        m_ld_grants = 0;
        m_forces    = 0;
        plg         = 1'b0;
        ldg         = 1'b0;
    endtask

    // One clock cycle: inputs are already driven (after a negedge)
    task automatic run_cycle();
        logic forcing;
        logic e_plr;
        logic e_ldr;
        logic s_ldv;
        logic s_iss;
        logic [AW-1:0] s_plrd;
        logic [AW-1:0] s_ldrd;
        logic [AW-1:0] s_isrd;
        logic [DW-1:0] s_pld;
        logic [DW-1:0] s_ldd;
        forcing = (lose_run >= int'(MAX_WAIT));
        e_plr   = !forcing;
        e_ldr   = forcing || !pl_valid;
        #1;
        obs_plr = pl_ready;
        obs_ldr = ld_ready;
        check("pl_ready", 64'(pl_ready), 64'(e_plr));
        check("ld_ready", 64'(ld_ready), 64'(e_ldr));
        check("rs1_busy", 64'(rs1_busy), 64'(m_busy[chk_rs1]));
        check("rs2_busy", 64'(rs2_busy), 64'(m_busy[chk_rs2]));
        check("rd_busy",  64'(rd_busy),  64'(m_busy[chk_rd]));
        plg    = pl_valid && e_plr;
        ldg    = ld_valid && e_ldr;
        s_ldv  = ld_valid;
        s_iss  = ld_issue;
        s_plrd = pl_rd;
        s_ldrd = ld_rd;
        s_isrd = ld_issue_rd;
        s_pld  = pl_data;
        s_ldd  = ld_data;
        @(posedge clk);
        #1;
        if (ldg) m_busy[s_ldrd] = 1'b0;
        if (s_iss && (s_isrd != '0)) m_busy[s_isrd] = 1'b1;
        exp_we = (plg && (s_plrd != '0)) || (ldg && (s_ldrd != '0));
        if (plg) begin
            exp_ad = s_plrd;
            exp_wd = s_pld;
            m_pl_grants++;
        end
        if (ldg) begin
            exp_ad = s_ldrd;
            exp_wd = s_ldd;
            m_ld_grants++;
        end
        if (forcing) lose_run = 0;
        else if (s_ldv && !e_ldr) lose_run++;
        else lose_run = 0;
        if (!forcing && (lose_run >= int'(MAX_WAIT))) m_forces++;
        check("we_out", 64'(we_out), 64'(exp_we));
        if (exp_we) begin
            check("ad_out", 64'(ad_out), 64'(exp_ad));
            check("wd_out", 64'(wd_out), 64'(exp_wd));
        end
        check("rs1_busy_post", 64'(rs1_busy), 64'(m_busy[chk_rs1]));
    endtask

    task automatic idle_inputs();
        pl_valid = 1'b0;
        ld_valid = 1'b0;
        ld_issue = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        pl_valid = 1'b0; pl_rd = '0; pl_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        model_reset();
        #1;
        check("rst_we", 64'(we_out), 64'(0));
        check("rst_ad", 64'(ad_out), 64'(0));
        check("rst_wd", 64'(wd_out), 64'(0));
        check("rst_pl_ready", 64'(pl_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Pipeline-only write
        pl_valid = 1'b1; pl_rd = 5'd7; pl_data = 32'hDEADBEEF;
        run_cycle();
        check("pl_we", 64'(we_out), 64'(1));
        check("pl_ad", 64'(ad_out), 64'(7));
        check("pl_wd", 64'(wd_out), 64'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        run_cycle();
        check("pl_we_drop", 64'(we_out), 64'(0));

        // Load wins an idle slot
        @(negedge clk);
        chk_rs1 = 5'd10;
        ld_issue = 1'b1; ld_issue_rd = 5'd10;
        run_cycle();
        check("ld_busy_set", 64'(rs1_busy), 64'(1));
        @(negedge clk);
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h55;
        run_cycle();
        check("ld_ad", 64'(ad_out), 64'(10));
        check("ld_wd", 64'(wd_out), 64'h55);
        check("ld_busy_clr", 64'(rs1_busy), 64'(0));

        // Starvation with MAX_WAIT=4
        @(negedge clk);
        pl_valid = 1'b1; pl_rd = 5'd1; pl_data = 32'h100;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hA5;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            check("starve_ldr", 64'(obs_ldr), 64'(i == 4));
            check("starve_plr", 64'(obs_plr), 64'(i != 4));
            if (i == 4) begin
                check("starve_ad", 64'(ad_out), 64'(12));
                check("starve_wd", 64'(wd_out), 64'hA5);
            end
            @(negedge clk);
            if (ldg) ld_valid = 1'b0;
            if (plg) begin
                pl_rd   = pl_rd + 5'd1;
                pl_data = pl_data + 32'd1;
            end
        end
        idle_inputs();

        // x0 write and same-cycle set/clear on the scoreboard
        pl_valid = 1'b1; pl_rd = 5'd0; pl_data = 32'h12345678;
        run_cycle();
        check("x0_pl_ready", 64'(obs_plr), 64'(1));
        check("x0_we", 64'(we_out), 64'(0));
        @(negedge clk);
        idle_inputs();
        chk_rd = 5'd3;
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        run_cycle();
        @(negedge clk);
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        run_cycle();
        check("set_wins", 64'(rd_busy), 64'(1));
        @(negedge clk);
        idle_inputs();

        // Reset while forcing a load, with busy[5] set and a write on the port
        ld_issue = 1'b1; ld_issue_rd = 5'd5;
        run_cycle();
        @(negedge clk);
        ld_issue = 1'b0;
        pl_valid = 1'b1; pl_rd = 5'd8; pl_data = 32'h800;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h900;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            @(negedge clk);
            if (plg) pl_data = pl_data + 32'd1;
        end
        chk_rs1 = 5'd5;
        #1;
        check("pre_rst_busy5", 64'(rs1_busy), 64'(1));
        check("pre_rst_we", 64'(we_out), 64'(1));
        check("pre_rst_force", 64'(pl_ready), 64'(0));
        rst = 1'b1;
        #1;
        check("async_rst_we", 64'(we_out), 64'(0));
        check("async_rst_busy5", 64'(rs1_busy), 64'(0));
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        pl_valid = 1'b1; pl_rd = 5'd4; pl_data = 32'h44;
        run_cycle();
        check("post_rst_plr", 64'(obs_plr), 64'(1));

        // Random traffic, requesters hold until granted
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!pl_valid || plg) begin
                pl_valid = ($urandom_range(0, 99) < 60);
                pl_rd    = AW'($urandom);
                pl_data  = $urandom;
            end
            if (!ld_valid || ldg) begin
                ld_valid = ($urandom_range(0, 99) < 35);
                ld_rd    = AW'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            ld_issue    = ($urandom_range(0, 99) < 25);
            ld_issue_rd = AW'($urandom_range(0, 7));
            chk_rs1     = AW'($urandom_range(0, 7));
            chk_rs2     = AW'($urandom_range(0, 7));
            chk_rd      = AW'($urandom_range(0, 7));
            run_cycle();
        end

`ifdef WB_ARB_STATS_EN
        check("pl_grant_cnt", 64'(pl_grant_cnt), 64'(m_pl_grants));
        check("ld_grant_cnt", 64'(ld_grant_cnt), 64'(m_ld_grants));
        check("force_cnt", 64'(force_cnt), 64'(m_forces));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (AD3/WD3/WE3) between two requesters: the in-order pipeline writeback and the cache load-return path for loads that miss and return late.
- Also keeps a 32-entry scoreboard of registers with a load in flight, so the hazard unit can stall readers.
- Sits between the writeback stage / cache return and register_file. Its registered outputs drive AD3/WD3/WE3 directly.

Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, write data width
- MAX_WAIT, 4, consecutive cycles a pending load return may lose arbitration before it is forced through (legal range 1..15)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- pl_valid  input  1  pipeline writeback request
- pl_rd  input  ADDR_WIDTH  pipeline destination register
- pl_data  input  DATA_WIDTH  pipeline write data
- pl_ready  output  1  pipeline request accepted this cycle; 0 stalls writeback
- ld_issue  input  1  a load miss was issued this cycle
- ld_issue_rd  input  ADDR_WIDTH  destination of the issued load
- ld_valid  input  1  load return request
- ld_rd  input  ADDR_WIDTH  load return destination
- ld_data  input  DATA_WIDTH  load return data
- ld_ready  output  1  load return accepted this cycle
- chk_rs1  input  ADDR_WIDTH  hazard query, first source
- chk_rs2  input  ADDR_WIDTH  hazard query, second source
- chk_rd  input  ADDR_WIDTH  hazard query, destination (write-after-write check)
- rs1_busy  output  1  scoreboard bit for chk_rs1
- rs2_busy  output  1  scoreboard bit for chk_rs2
- rd_busy  output  1  scoreboard bit for chk_rd
- we_out  output  1  to register_file WE3
- ad_out  output  ADDR_WIDTH  to register_file AD3
- wd_out  output  DATA_WIDTH  to register_file WD3

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: we_out=0, ad_out=0, wd_out=0.
  - State: scoreboard all 0, starve_cnt=0, state=PL_PRIO.
  - A request in flight when reset asserts is dropped; no partial write occurs.
- State machine, two states:
  - PL_PRIO:
    - pl_ready=1.
    - ld_ready = !pl_valid.
  - LD_FORCE:
    - pl_ready=0.
    - ld_ready=1.
- Handshake and grant:
  - A request is granted when valid && ready. At most one grant per cycle.
  - Ready is combinational from state and pl_valid only, never from ld_valid.
  - A requester holds valid, rd and data stable until granted.
- Output latency:
  - A grant in cycle T drives we_out/ad_out/wd_out from posedge T+1 for exactly one cycle. register_file captures the write on the negedge of that same cycle.
  - With no grant, we_out=0 next cycle; ad_out/wd_out hold their last value.
- x0 writes: a grant with rd=0 completes the handshake normally but forces we_out=0.
- starve_cnt (4 bits), evaluated in PL_PRIO:
  - Increments when ld_valid && !ld_ready.
  - Clears when ld_valid=0 or the load is granted.
- Transitions:
  - PL_PRIO -> LD_FORCE when ld_valid && !ld_ready && starve_cnt == MAX_WAIT-1.
  - LD_FORCE -> PL_PRIO on a load grant, or if ld_valid is 0. starve_cnt clears on exit.
- Scoreboard:
  - Set: ld_issue with ld_issue_rd != 0 sets busy[ld_issue_rd] at the next posedge.
  - Clear: a load grant clears busy[ld_rd] at the next posedge.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is constant 0.
  - rsX_busy / rd_busy are combinational reads of the registered bits. There is no same-cycle bypass of a clear.
- Pipeline writes never touch the scoreboard.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, adds these outputs, all reset to 0 and saturating at all-ones:
  - pl_grant_cnt, 32-bit: counts pipeline grants.
  - ld_grant_cnt, 32-bit: counts load grants.
  - force_cnt, 16-bit: counts PL_PRIO->LD_FORCE entries.
- When undefined, these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Pipeline-only write:
  - Stimulus: pl_valid=1, pl_rd=7, pl_data=0xDEADBEEF for one cycle.
  - Response: next cycle we_out=1, ad_out=7, wd_out=0xDEADBEEF. The cycle after, we_out=0.
- Load wins an idle slot:
  - Stimulus: ld_issue rd=10; then ld_valid rd=10, data=0x55 with pl_valid=0.
  - Response: rs1_busy=1 for chk_rs1=10 until the grant. Next cycle ad_out=10, wd_out=0x55, then busy clears.
- Starvation, MAX_WAIT=4:
  - Stimulus: pl_valid held 1; ld_valid asserted at cycle 0.
  - Response: ld_ready=0 for cycles 0-3; cycle 4 pl_ready=0, ld_ready=1. The load write appears at cycle 5 and pl_ready=1 returns at cycle 5.
- x0 and scoreboard conflict:
  - Stimulus 1: pl grant with rd=0 -> pl_ready=1, we_out stays 0.
  - Stimulus 2: ld_issue rd=3 in the same cycle as a load grant with rd=3 -> busy[3]=1 afterwards.
- Reset mid-operation:
  - Stimulus: assert rst while in LD_FORCE with busy[5]=1 and we_out=1.
  - Response: we_out=0 and all busy bits 0 immediately, without waiting for a clock. After release, state=PL_PRIO and pl_ready=1.
- Stats build:
  - Stimulus: with WB_ARB_STATS_EN defined, run 3 pipeline grants, 2 load grants and 1 forced entry.
  - Response: pl_grant_cnt=3, ld_grant_cnt=2, force_cnt=1.
